// File: rtl/bldc_commutator.sv
// Six-step BLDC commutator: hall sync/filter, sector decode, signed PWM with
// shadowed duty, per-phase deadtime, brake/enable, hall fault and step counter.
module bldc_commutator #(
   parameter int unsigned PWM_WIDTH   = 10,
   parameter int unsigned DEADTIME    = 16,
   parameter int unsigned HALL_FILTER = 4,
   parameter int unsigned POS_WIDTH   = 16
) (
   input  logic                        CLK,
   input  logic                        reset,
   input  logic                        hall1,
   input  logic                        hall2,
   input  logic                        hall3,
   input  logic signed [PWM_WIDTH:0]   pwm,
   input  logic                        enable,
   input  logic                        brake,
   output logic [5:0]                  GATES,
   output logic [2:0]                  hall_state,
   output logic                        hall_fault,
   output logic signed [POS_WIDTH-1:0] position,
   output logic                        step_error,
   output logic                        period_tick
);

   localparam int unsigned FiltW = $clog2(HALL_FILTER + 1);
   localparam int unsigned DtW   = (DEADTIME > 0) ? $clog2(DEADTIME + 1) : 1;
   localparam logic [PWM_WIDTH-1:0] CntMax  = '1;
   localparam logic [FiltW-1:0]     FiltMax = FiltW'(HALL_FILTER);
   localparam logic [DtW-1:0]       DtMax   = DtW'(DEADTIME);
   localparam logic [2:0]           SecInv  = 3'd7;

   function automatic logic [2:0] sector_of(input logic [2:0] h);
      case (h)
         3'b101:  sector_of = 3'd0;
         3'b100:  sector_of = 3'd1;
         3'b110:  sector_of = 3'd2;
         3'b010:  sector_of = 3'd3;
         3'b011:  sector_of = 3'd4;
         3'b001:  sector_of = 3'd5;
         default: sector_of = SecInv;
      endcase
   endfunction

   logic [2:0]                  sync1_q, sync2_q, cand_q, cand_d, hall_q, hall_d;
   logic [FiltW-1:0]            filt_cnt_q, filt_cnt_d;
   logic                        qual_q, qual_d, hall_upd;
   logic signed [POS_WIDTH-1:0] pos_q, pos_d;
   logic                        step_err_q, step_err_d;
   logic [PWM_WIDTH-1:0]        pwm_cnt_q, pwm_cnt_d, mag_q, mag_d, mag_sat;
   logic                        dir_q, dir_d, pwm_on;
   logic signed [PWM_WIDTH:0]   pwm_neg;
   logic [PWM_WIDTH:0]          pwm_abs;
   logic [5:0]                  gates_q, gates_d, req, fwd_pat;
   logic [DtW-1:0]              dt_q [3];
   logic [DtW-1:0]              dt_d [3];
   logic [2:0]                  s_old, s_new, s_inc, s_dec, s_req;

   // Hall filter and step counter
   always_comb begin
      cand_d     = sync2_q;
      filt_cnt_d = filt_cnt_q;
      if (sync2_q != cand_q) begin
         filt_cnt_d = FiltW'(1);
      end else if (filt_cnt_q < FiltMax) begin
         filt_cnt_d = filt_cnt_q + FiltW'(1);
      end
      hall_upd = (filt_cnt_d == FiltMax) && ((sync2_q != hall_q) || !qual_q);
      hall_d   = hall_upd ? sync2_q : hall_q;
      qual_d   = qual_q | hall_upd;

      s_old      = sector_of(hall_q);
      s_new      = sector_of(sync2_q);
      s_inc      = (s_old == 3'd5) ? 3'd0 : s_old + 3'd1;
      s_dec      = (s_old == 3'd0) ? 3'd5 : s_old - 3'd1;
      pos_d      = pos_q;
      step_err_d = 1'b0;
      if (hall_upd && s_old != SecInv && s_new != SecInv && s_old != s_new) begin
         if (s_new == s_inc) begin
            pos_d = pos_q + POS_WIDTH'(1);
         end else if (s_new == s_dec) begin
            pos_d = pos_q - POS_WIDTH'(1);
         end else begin
            step_err_d = 1'b1;
         end
      end
   end

   // PWM counter and duty/direction shadows; -2^W wraps to 2^W unsigned, then saturates
   always_comb begin
      period_tick = (pwm_cnt_q == CntMax);
      pwm_cnt_d   = pwm_cnt_q + PWM_WIDTH'(1);
      pwm_neg     = -pwm;
      pwm_abs     = pwm[PWM_WIDTH] ? unsigned'(pwm_neg) : unsigned'(pwm);
      mag_sat     = pwm_abs[PWM_WIDTH] ? CntMax : pwm_abs[PWM_WIDTH-1:0];
      mag_d       = mag_q;
      dir_d       = dir_q;
      if (period_tick) begin
         mag_d = mag_sat;
         dir_d = pwm[PWM_WIDTH];
      end
      pwm_on = (pwm_cnt_q < mag_q);
   end

   // Request uses the next hall value so a fault blanks the gates on the same edge
   always_comb begin
      s_req = sector_of(hall_d);
      case (s_req)
         3'd0:    fwd_pat = 6'b100100;
         3'd1:    fwd_pat = 6'b100001;
         3'd2:    fwd_pat = 6'b001001;
         3'd3:    fwd_pat = 6'b011000;
         3'd4:    fwd_pat = 6'b010010;
         3'd5:    fwd_pat = 6'b000110;
         default: fwd_pat = 6'b000000;
      endcase
      req = 6'b000000;
      if (enable && qual_d && s_req != SecInv) begin
         if (brake) begin
            req = 6'b010101;
         end else if (pwm_on) begin
            // Reverse swaps high and low side within every phase
            req = dir_q ? {fwd_pat[4], fwd_pat[5], fwd_pat[2], fwd_pat[3], fwd_pat[0], fwd_pat[1]}
                        : fwd_pat;
         end
      end
   end

   // Per-phase deadtime: a gate may only rise after the pair has been idle DEADTIME cycles
   always_comb begin
      gates_d = '0;
      for (int p = 0; p < 3; p++) begin
         if (req[5-2*p] && !req[4-2*p] &&
             (gates_q[5-2*p] || (!gates_q[4-2*p] && dt_q[p] == DtMax))) begin
            gates_d[5-2*p] = 1'b1;
         end
         if (req[4-2*p] && !req[5-2*p] &&
             (gates_q[4-2*p] || (!gates_q[5-2*p] && dt_q[p] == DtMax))) begin
            gates_d[4-2*p] = 1'b1;
         end
         if (gates_d[5-2*p] || gates_d[4-2*p]) begin
            dt_d[p] = '0;
         end else if (dt_q[p] < DtMax) begin
            dt_d[p] = dt_q[p] + DtW'(1);
         end else begin
            dt_d[p] = dt_q[p];
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (reset) begin
         sync1_q    <= '0;
         sync2_q    <= '0;
         cand_q     <= '0;
         filt_cnt_q <= '0;
         hall_q     <= '0;
         qual_q     <= 1'b0;
         pos_q      <= '0;
         step_err_q <= 1'b0;
         pwm_cnt_q  <= '0;
         mag_q      <= '0;
         dir_q      <= 1'b0;
         gates_q    <= '0;
         for (int p = 0; p < 3; p++) begin
            dt_q[p] <= '0;
         end
      end else begin
         sync1_q    <= {hall1, hall2, hall3};
         sync2_q    <= sync1_q;
         cand_q     <= cand_d;
         filt_cnt_q <= filt_cnt_d;
         hall_q     <= hall_d;
         qual_q     <= qual_d;
         pos_q      <= pos_d;
         step_err_q <= step_err_d;
         pwm_cnt_q  <= pwm_cnt_d;
         mag_q      <= mag_d;
         dir_q      <= dir_d;
         gates_q    <= gates_d;
         for (int p = 0; p < 3; p++) begin
            dt_q[p] <= dt_d[p];
         end
      end
   end

   assign GATES      = gates_q;
   assign hall_state = hall_q;
   assign hall_fault = qual_q && (sector_of(hall_q) == SecInv);
   assign position   = pos_q;
   assign step_error = step_err_q;

endmodule

// File: tb/tb_bldc_commutator.sv
// Bench for bldc_commutator: default instance plus a zero-deadtime instance on shared inputs.
module tb_bldc_commutator;

   logic               CLK = 1'b0;
   logic               reset, hall1, hall2, hall3, enable, brake;
   logic signed [10:0] pwm;
   logic [5:0]         GATES, gates_nd;
   logic [2:0]         hall_state, hall_state_nd;
   logic               hall_fault, hall_fault_nd, step_error, step_error_nd;
   logic               period_tick, period_tick_nd;
   logic signed [15:0] position, position_nd;

   int n_checks = 0;
   int n_fail   = 0;
   int exp_q[$];

   bldc_commutator dut (
      .CLK(CLK), .reset(reset), .hall1(hall1), .hall2(hall2), .hall3(hall3), .pwm(pwm),
      .enable(enable), .brake(brake), .GATES(GATES), .hall_state(hall_state),
      .hall_fault(hall_fault), .position(position), .step_error(step_error),
      .period_tick(period_tick)
   );

   bldc_commutator #(.DEADTIME(0)) dut_nd (
      .CLK(CLK), .reset(reset), .hall1(hall1), .hall2(hall2), .hall3(hall3), .pwm(pwm),
      .enable(enable), .brake(brake), .GATES(gates_nd), .hall_state(hall_state_nd),
      .hall_fault(hall_fault_nd), .position(position_nd), .step_error(step_error_nd),
      .period_tick(period_tick_nd)
   );

   always #5 CLK = ~CLK;

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic set_hall(input logic [2:0] h);
      {hall1, hall2, hall3} = h;
   endtask

   // Returns at a sample where period_tick is high (the next edge is the wrap)
   task automatic wait_tick();
      bit ok = period_tick;
      for (int i = 0; i < 2100 && !ok; i++) begin
         tick();
         ok = period_tick;
      end
      n_checks++;
      if (!ok) begin
         n_fail++;
         $display("FAIL wait_period_tick: got no tick, want tick within 2100 cycles");
      end
   endtask

   task automatic measure_period(input logic [5:0] pat, input int change_at,
                                 input logic signed [10:0] new_pwm,
                                 output int on_cnt, output int bad_cnt, output int tick_cnt);
      on_cnt = 0; bad_cnt = 0; tick_cnt = 0;
      wait_tick();
      for (int i = 0; i < 1024; i++) begin
         tick();
         if (GATES === pat) on_cnt++;
         else if (GATES !== 6'b0) bad_cnt++;
         if (period_tick) tick_cnt++;
         if (i == change_at) pwm = new_pwm;
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; enable = 1'b0; brake = 1'b0; pwm = '0;
      set_hall(3'b101);
      repeat (3) tick();
      n_checks++;
      if ({GATES, hall_state, hall_fault, position, step_error, period_tick} !== '0) begin
         n_fail++;
         $display("FAIL reset_values: got G=%b h=%b f=%b p=%0d e=%b t=%b, want all zero",
                  GATES, hall_state, hall_fault, position, step_error, period_tick);
      end
      reset = 1'b0;
      for (int k = 1; k <= 6; k++) begin
         tick();
         if (k == 5) begin
            n_checks++;
            if (hall_state !== 3'b000 || hall_fault !== 1'b0) begin
               n_fail++;
               $display("FAIL unqualified_hall: got h=%b f=%b, want 000/0", hall_state, hall_fault);
            end
         end
         if (k == 6) begin
            n_checks++;
            if (hall_state !== 3'b101) begin
               n_fail++;
               $display("FAIL hall_qualify_latency: got %b, want 101", hall_state);
            end
         end
      end
   endtask

   task automatic test_duty();
      int on_c, bad_c, tk_c;
      enable = 1'b1;
      pwm = 11'sd256;
      exp_q.push_back(256);
      measure_period(6'b100100, -1, 11'sd0, on_c, bad_c, tk_c);
      n_checks++;
      if (on_c != exp_q.pop_front() || bad_c != 0 || tk_c != 1) begin
         n_fail++;
         $display("FAIL duty_fwd_256: got on=%0d bad=%0d ticks=%0d, want 256/0/1", on_c, bad_c, tk_c);
      end
      pwm = -11'sd256;
      exp_q.push_back(256);
      measure_period(6'b011000, -1, 11'sd0, on_c, bad_c, tk_c);
      n_checks++;
      if (on_c != exp_q.pop_front() || bad_c != 0 || tk_c != 1) begin
         n_fail++;
         $display("FAIL duty_rev_256: got on=%0d bad=%0d ticks=%0d, want 256/0/1", on_c, bad_c, tk_c);
      end
   endtask

   task automatic test_shadow();
      int on_c, bad_c, tk_c;
      pwm = 11'sd100;
      exp_q.push_back(100);
      exp_q.push_back(900);
      measure_period(6'b100100, 500, 11'sd900, on_c, bad_c, tk_c);
      n_checks++;
      if (on_c != exp_q.pop_front() || bad_c != 0) begin
         n_fail++;
         $display("FAIL shadow_hold: got on=%0d bad=%0d, want 100/0", on_c, bad_c);
      end
      measure_period(6'b100100, -1, 11'sd0, on_c, bad_c, tk_c);
      n_checks++;
      if (on_c != exp_q.pop_front() || bad_c != 0) begin
         n_fail++;
         $display("FAIL shadow_load: got on=%0d bad=%0d, want 900/0", on_c, bad_c);
      end
      pwm = -11'sd1024;
      exp_q.push_back(1023);
      measure_period(6'b011000, -1, 11'sd0, on_c, bad_c, tk_c);
      n_checks++;
      if (on_c != exp_q.pop_front() || bad_c != 0) begin
         n_fail++;
         $display("FAIL saturate_neg: got on=%0d bad=%0d, want 1023/0", on_c, bad_c);
      end
   endtask

   task automatic test_step();
      logic [2:0] seq [4] = '{3'b100, 3'b110, 3'b100, 3'b010};
      int         epos [4] = '{1, 2, 1, 1};
      bit         eerr [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
      int         err_cnt, err_at, e;
      for (int j = 0; j < 4; j++) begin
         set_hall(seq[j]);
         exp_q.push_back(epos[j]);
         err_cnt = 0; err_at = -1;
         for (int k = 1; k <= 10; k++) begin
            tick();
            if (step_error) begin
               err_cnt++;
               err_at = k;
            end
         end
         e = exp_q.pop_front();
         n_checks++;
         if (position !== 16'(e) || hall_state !== seq[j]) begin
            n_fail++;
            $display("FAIL step_position_%0d: got p=%0d h=%b, want %0d/%b",
                     j, position, hall_state, e, seq[j]);
         end
         n_checks++;
         if (err_cnt != int'(eerr[j]) || (eerr[j] && err_at != 6)) begin
            n_fail++;
            $display("FAIL step_error_%0d: got pulses=%0d at=%0d, want %0d at 6",
                     j, err_cnt, err_at, eerr[j]);
         end
      end
   endtask

   task automatic test_fault();
      int bad;
      brake = 1'b1;
      repeat (20) tick();
      n_checks++;
      if (GATES !== 6'b010101) begin
         n_fail++;
         $display("FAIL brake_pattern: got %b, want 010101", GATES);
      end
      set_hall(3'b111);
      for (int k = 1; k <= 6; k++) begin
         tick();
         if (k == 5) begin
            n_checks++;
            if (GATES !== 6'b010101 || hall_fault !== 1'b0) begin
               n_fail++;
               $display("FAIL fault_early: got G=%b f=%b, want 010101/0", GATES, hall_fault);
            end
         end
         if (k == 6) begin
            n_checks++;
            if (GATES !== 6'b0 || hall_fault !== 1'b1) begin
               n_fail++;
               $display("FAIL fault_latency: got G=%b f=%b, want 000000/1", GATES, hall_fault);
            end
         end
      end
      set_hall(3'b100);
      repeat (3) tick();
      set_hall(3'b111);
      bad = 0;
      repeat (15) begin
         tick();
         if (hall_state !== 3'b111 || hall_fault !== 1'b1) bad++;
      end
      n_checks++;
      if (bad != 0) begin
         n_fail++;
         $display("FAIL glitch_reject: got %0d disturbed cycles, want 0", bad);
      end
      set_hall(3'b101);
      brake = 1'b0;
      repeat (8) tick();
      n_checks++;
      if (hall_state !== 3'b101 || hall_fault !== 1'b0 || position !== 16'sd1) begin
         n_fail++;
         $display("FAIL fault_recover: got h=%b f=%b p=%0d, want 101/0/1",
                  hall_state, hall_fault, position);
      end
   endtask

   task automatic test_deadtime_brake();
      int la_first = -1, la_nd_first = -1, overlap = 0;
      pwm = 11'sd1000;
      wait_tick();
      repeat (20) tick();
      n_checks++;
      if (GATES !== 6'b100100 || gates_nd !== 6'b100100) begin
         n_fail++;
         $display("FAIL pre_brake_on: got %b/%b, want 100100/100100", GATES, gates_nd);
      end
      brake = 1'b1;
      for (int k = 1; k <= 20; k++) begin
         tick();
         if (k == 1) begin
            n_checks++;
            if (GATES !== 6'b000101 || gates_nd !== 6'b000101) begin
               n_fail++;
               $display("FAIL brake_ha_off: got %b/%b, want 000101/000101", GATES, gates_nd);
            end
         end
         if (la_first < 0 && GATES[4]) la_first = k;
         if (la_nd_first < 0 && gates_nd[4]) la_nd_first = k;
         if ((GATES[5] & GATES[4]) | (GATES[3] & GATES[2]) | (GATES[1] & GATES[0])) overlap++;
         if ((gates_nd[5] & gates_nd[4]) | (gates_nd[3] & gates_nd[2]) |
             (gates_nd[1] & gates_nd[0])) overlap++;
      end
      n_checks++;
      if (la_first != 17) begin
         n_fail++;
         $display("FAIL deadtime_16: got LA at cycle %0d, want 17", la_first);
      end
      n_checks++;
      if (la_nd_first != 2) begin
         n_fail++;
         $display("FAIL deadtime_0: got LA at cycle %0d, want 2", la_nd_first);
      end
      n_checks++;
      if (overlap != 0) begin
         n_fail++;
         $display("FAIL shoot_through: got %0d overlap cycles, want 0", overlap);
      end
      brake = 1'b0;
   endtask

   task automatic test_enable_reset();
      int first_on = -1;
      wait_tick();
      repeat (30) tick();
      enable = 1'b0;
      tick();
      n_checks++;
      if (GATES !== 6'b0) begin
         n_fail++;
         $display("FAIL enable_off: got %b, want 000000", GATES);
      end
      enable = 1'b1;
      repeat (30) tick();
      n_checks++;
      if (GATES !== 6'b100100) begin
         n_fail++;
         $display("FAIL enable_resume: got %b, want 100100", GATES);
      end
      reset = 1'b1;
      tick();
      n_checks++;
      if ({GATES, hall_state, hall_fault, position, step_error, period_tick} !== '0) begin
         n_fail++;
         $display("FAIL midrun_reset: got G=%b h=%b f=%b p=%0d e=%b t=%b, want all zero",
                  GATES, hall_state, hall_fault, position, step_error, period_tick);
      end
      reset = 1'b0;
      for (int k = 1; k <= 1100; k++) begin
         tick();
         if (k == 6) begin
            n_checks++;
            if (hall_state !== 3'b101) begin
               n_fail++;
               $display("FAIL requalify: got %b, want 101", hall_state);
            end
         end
         if (first_on < 0 && GATES !== 6'b0) first_on = k;
      end
      n_checks++;
      if (first_on != 1025) begin
         n_fail++;
         $display("FAIL first_pulse_after_reset: got cycle %0d, want 1025", first_on);
      end
   endtask

   initial begin
      test_reset();
      test_duty();
      test_shadow();
      test_step();
      test_fault();
      test_deadtime_brake();
      test_enable_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got simulation still running, want completion");
      $fatal(1, "watchdog expired");
   end

endmodule
